rr_arb_mux: RTL and testbench

- Parametrised N-input, W-bit multiplexer with round-robin arbitration, valid/ready handshakes on every input and on the output, and a registered output stage.
- Generalises the single-bit 2:1 select into multi-channel, multi-bit steering with fairness and backpressure.
- Sits between multiple requesters, such as fetch, load/store and debug ports, and a single shared consumer, such as the memory port.

---
 rtl/rr_arb_mux_pkg.sv | 22 ++
 rtl/rr_arb_mux_if.sv | 30 +++
 rtl/rr_arb_mux_rr_pick.sv | 41 ++++
 rtl/rr_arb_mux.sv | 113 +++++++++++
 tb/tb_rr_arb_mux.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/rr_arb_mux_pkg.sv
// Shared definitions for the round-robin arbitrating mux: default sizing,
// an index-width helper and the grant-mode encoding.
package rr_arb_mux_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_NUM_IN = 4;

  // Number of bits needed to index n items (returns at least 1).
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  // Which grant source drives the data select this cycle.
  typedef enum logic {
    SEL_RR     = 1'b0,
    SEL_FORCED = 1'b1
  } selMode_e;

endpackage

// File: rtl/rr_arb_mux_if.sv
// Handshake bundle between the requesters, the arbitrating mux and the
// shared consumer. The master side is the environment (requesters plus
// consumer); the slave side is the mux itself.
interface rr_arb_mux_if #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic                    force_en;
  logic [SEL_W-1:0]        force_sel;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_src;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_valid, force_en, force_sel, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );

  modport slave (
    input  in_data, in_valid, force_en, force_sel, out_ready,
    output in_ready, out_data, out_src, out_valid
  );

endinterface

// File: rtl/rr_arb_mux_rr_pick.sv
// Combinational round-robin picker: the channel just after ptr has the
// highest priority, wrapping modulo NUM_IN.
module rr_pick
  import rr_arb_mux_pkg::*;
#(
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W  = clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  gnt,
  output logic              gntVld
);

  logic [2*NUM_IN-1:0] reqDbl;
  logic [NUM_IN-1:0]   reqRot;
  int                  shAmt;
  int                  peIdx;

  // Rotate requests so that channel ptr+1 lands in bit 0. ptr never exceeds
  // NUM_IN-1, so shAmt stays within 0..NUM_IN-1.
  always_comb begin
    shAmt  = (int'(ptr) + 1) % NUM_IN;
    reqDbl = {req, req};
    reqRot = NUM_IN'(reqDbl >> shAmt);
  end

  // Fixed-priority encode (lowest rotated bit wins), then rotate the index back.
  always_comb begin
    peIdx  = 0;
    gntVld = 1'b0;
    for (int j = NUM_IN - 1; j >= 0; j--) begin
      if (reqRot[j]) begin
        peIdx  = j;
        gntVld = 1'b1;
      end
    end
    gnt = SEL_W'((shAmt + peIdx) % NUM_IN);
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-input, W-bit arbitrating mux with a single registered output stage.
// Round-robin or forced channel selection, valid/ready on every port,
// one beat per cycle when the consumer keeps up.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W  = clog2(NUM_IN)
) (
  input logic        clk,
  input logic        rst_n,
  rr_arb_mux_if.slave bus
);

  localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(NUM_IN - 1);

  logic [SEL_W-1:0]  ptrQ;
  logic [WIDTH-1:0]  outDataQ;
  logic [SEL_W-1:0]  outSrcQ;
  logic              outValidQ;

  logic [SEL_W-1:0]  rrGnt;
  logic              rrVld;
  logic              forceVld;
  selMode_e          mode;
  logic [SEL_W-1:0]  gnt;
  logic              gntVld;
  logic              loadOk;
  logic              xfer;
  logic [NUM_IN-1:0] readyVec;
  logic [WIDTH-1:0]  selData;

  rr_pick #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) uPick (
    .req    (bus.in_valid),
    .ptr    (ptrQ),
    .gnt    (rrGnt),
    .gntVld (rrVld)
  );

  // Forced channel validity; an out-of-range force_sel matches no channel.
  always_comb begin
    forceVld = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (bus.force_sel == SEL_W'(i)) forceVld = bus.in_valid[i];
    end
  end

  // Choose the grant source; mode changes apply in the same cycle.
  always_comb begin
    mode   = bus.force_en ? SEL_FORCED : SEL_RR;
    gnt    = rrGnt;
    gntVld = rrVld;
    case (mode)
      SEL_FORCED: begin
        gnt    = bus.force_sel;
        gntVld = forceVld;
      end
      default: begin
        gnt    = rrGnt;
        gntVld = rrVld;
      end
    endcase
  end

  assign loadOk = !outValidQ || bus.out_ready;
  assign xfer   = loadOk && gntVld;

  // One-hot accept toward the granted requester; nothing is accepted while
  // reset is asserted so no requester believes a beat was taken.
  always_comb begin
    readyVec = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      readyVec[i] = rst_n && xfer && (gnt == SEL_W'(i));
    end
  end

  // Data select by compare rather than a variable part-select, so an
  // out-of-range grant index can never address past the bus.
  always_comb begin
    selData = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt == SEL_W'(i)) selData = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // Output register and last-grant pointer: load on transfer, clear valid on
  // drain, hold everything on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValidQ <= 1'b0;
      outDataQ  <= '0;
      outSrcQ   <= '0;
      ptrQ      <= PTR_RST;
    end else if (xfer) begin
      outValidQ <= 1'b1;
      outDataQ  <= selData;
      outSrcQ   <= gnt;
      ptrQ      <= gnt;
    end else if (bus.out_ready) begin
      outValidQ <= 1'b0;
    end
  end

  assign bus.in_ready  = readyVec;
  assign bus.out_data  = outDataQ;
  assign bus.out_src   = outSrcQ;
  assign bus.out_valid = outValidQ;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: a table of per-cycle stimulus with hand-derived
// expected in_ready, plus hand sequences for stall and reset corners.
// Accepted beats go into a scoreboard queue and are checked on the output.
module tb_rr_arb_mux;

  localparam int WIDTH  = 16;
  localparam int NUM_IN = 4;
  localparam int SEL_W  = 2;

  typedef struct {
    logic [NUM_IN-1:0] vld;
    logic              fen;
    logic [SEL_W-1:0]  fsel;
    logic              ordy;
    logic [NUM_IN-1:0] expRdy;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] src;
  } beat_t;

  logic clk;
  logic rst_n;

  rr_arb_mux_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) bus ();

  rr_arb_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t             tbl[$];
  beat_t            sb[$];
  logic [WIDTH-1:0] chData[NUM_IN];
  logic             mOutValid;
  int               nVec;
  int               nBad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic void addVec(input logic [NUM_IN-1:0] vld, input logic fen,
                                 input logic [SEL_W-1:0] fsel, input logic ordy,
                                 input logic [NUM_IN-1:0] expRdy);
    vec_t v;
    v.vld = vld; v.fen = fen; v.fsel = fsel; v.ordy = ordy; v.expRdy = expRdy;
    tbl.push_back(v);
  endfunction

  // Drive one cycle's inputs, check against expectations, update the scoreboard.
  task automatic apply(input vec_t v);
    beat_t b;
    bus.in_valid  = v.vld;
    bus.force_en  = v.fen;
    bus.force_sel = v.fsel;
    bus.out_ready = v.ordy;
    for (int i = 0; i < NUM_IN; i++) bus.in_data[i*WIDTH +: WIDTH] = chData[i];
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(v.expRdy));
    chk("out_valid", 32'(bus.out_valid), 32'(mOutValid));
    if (mOutValid) begin
      if (sb.size() == 0) begin
        nVec++; nBad++;
        $display("FAIL scoreboard at %0t: got empty queue expected a beat", $time);
      end else begin
        chk("out_data", 32'(bus.out_data), 32'(sb[0].data));
        chk("out_src", 32'(bus.out_src), 32'(sb[0].src));
        if (v.ordy) void'(sb.pop_front());
      end
    end
    if (v.expRdy != '0) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (v.expRdy[i]) begin
          b.data = chData[i];
          b.src  = SEL_W'(i);
        end
      end
      sb.push_back(b);
      mOutValid = 1'b1;
    end else if (v.ordy) begin
      mOutValid = 1'b0;
    end
  endtask

  task automatic step(input logic [NUM_IN-1:0] vld, input logic fen,
                      input logic [SEL_W-1:0] fsel, input logic ordy,
                      input logic [NUM_IN-1:0] expRdy);
    vec_t v;
    v.vld = vld; v.fen = fen; v.fsel = fsel; v.ordy = ordy; v.expRdy = expRdy;
    @(negedge clk);
    apply(v);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish by 100000");
    $fatal(1, "timeout");
  end

  initial begin
    nVec = 0;
    nBad = 0;
    mOutValid = 1'b0;
    for (int i = 0; i < NUM_IN; i++) chData[i] = 16'hA0A0 + 16'(i);

    // round-robin over all channels
    for (int k = 0; k < 8; k++) addVec(4'b1111, 0, 0, 1, 4'b0001 << (k % 4));
    // sparse requesters alternate, then a lone requester streams without bubbles
    addVec(4'b1010, 0, 0, 1, 4'b0010);
    addVec(4'b1010, 0, 0, 1, 4'b1000);
    addVec(4'b1010, 0, 0, 1, 4'b0010);
    addVec(4'b1010, 0, 0, 1, 4'b1000);
    addVec(4'b0010, 0, 0, 1, 4'b0010);
    addVec(4'b0010, 0, 0, 1, 4'b0010);
    addVec(4'b0010, 0, 0, 1, 4'b0010);
    // stall then resume after last grant ch1
    addVec(4'b1111, 0, 0, 0, 4'b0000);
    addVec(4'b1111, 0, 0, 0, 4'b0000);
    addVec(4'b1111, 0, 0, 1, 4'b0100);
    // forced ch2, forced-but-idle, then round-robin resumes after ch2
    addVec(4'b1111, 1, 2, 1, 4'b0100);
    addVec(4'b1111, 1, 2, 1, 4'b0100);
    addVec(4'b1111, 1, 2, 1, 4'b0100);
    addVec(4'b1011, 1, 2, 1, 4'b0000);
    addVec(4'b1111, 0, 0, 1, 4'b1000);
    addVec(4'b1111, 1, 0, 1, 4'b0001);
    addVec(4'b1111, 0, 0, 1, 4'b0010);
    addVec(4'b0111, 1, 3, 1, 4'b0000);
    addVec(4'b0000, 0, 0, 1, 4'b0000);

    // reset with all channels requesting
    rst_n         = 1'b0;
    bus.in_valid  = 4'b1111;
    bus.force_en  = 1'b0;
    bus.force_sel = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < NUM_IN; i++) bus.in_data[i*WIDTH +: WIDTH] = chData[i];
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst out_data", 32'(bus.out_data), 32'd0);
    chk("rst out_src", 32'(bus.out_src), 32'd0);
    chk("rst in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = '0;
    rst_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      apply(tbl[k]);
    end

    // held beat of 16'h1234 from ch2 stays stable through a 3-cycle stall
    chData[2] = 16'h1234;
    step(4'b0100, 0, 0, 1, 4'b0100);
    step(4'b1111, 0, 0, 0, 4'b0000);
    step(4'b1111, 0, 0, 0, 4'b0000);
    step(4'b1111, 0, 0, 0, 4'b0000);
    step(4'b1111, 0, 0, 1, 4'b1000);
    step(4'b1111, 0, 0, 0, 4'b0000);

    // async reset pulse between edges while a beat is stalled
    @(negedge clk);
    #1;
    chk("pre-rst out_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst in_ready", 32'(bus.in_ready), 32'd0);
    sb.delete();
    mOutValid = 1'b0;
    #1;
    rst_n = 1'b1;
    begin
      vec_t v;
      v.vld = 4'b1111; v.fen = 1'b0; v.fsel = '0; v.ordy = 1'b1; v.expRdy = 4'b0001;
      apply(v);
    end
    step(4'b1111, 0, 0, 1, 4'b0010);
    step(4'b0000, 0, 0, 1, 4'b0000);
    step(4'b0000, 0, 0, 1, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
